// File: rtl/i2c_pkg.sv
// Shared encodings for the single-byte I2C master: FSM states, quarter phases,
// slot counts and the SCL/SDA drive pattern per state and phase.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    ACK1  = 3'd3,
    DATA  = 3'd4,
    ACK2  = 3'd5,
    STOP  = 3'd6,
    DONE  = 3'd7
  } i2c_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int unsigned SLOTS_FULL      = 20;
  localparam int unsigned SLOTS_ADDR_NACK = 11;

  // Returns {scl_low, sda_low}; bit_v is the data bit to present (1 = released).
  function automatic logic [1:0] bus_drive(input i2c_state_e st, input logic [1:0] ph,
                                           input logic bit_v);
    logic scl_low;
    logic sda_low;
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (st)
      START: begin
        scl_low = (ph == Q3);
        sda_low = (ph >= Q2);
      end
      ADDR, DATA: begin
        scl_low = (ph <= Q1);
        sda_low = ~bit_v;
      end
      ACK1, ACK2: begin
        scl_low = (ph <= Q1);
        sda_low = 1'b0;
      end
      STOP: begin
        scl_low = (ph <= Q1);
        sda_low = (ph != Q3);
      end
      default: begin
        scl_low = 1'b0;
        sda_low = 1'b0;
      end
    endcase
    return {scl_low, sda_low};
  endfunction

endpackage

// File: rtl/i2c_master_byte_if.sv
// Command/response handshake and open-drain pad signals of the I2C master.
// The master modport is the I2C block itself; slave is the requester/pad side.
interface i2c_master_byte_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_rw;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       scl_i;
  logic       sda_i;

  modport master (
    input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata, scl_i, sda_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy, scl_oe, sda_oe
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_rw, cmd_wdata, scl_i, sda_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, busy, scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_qtick_gen.sv
// Quarter-period tick generator: counts QDIV clk per quarter and steps a 2-bit
// phase. clr_i restarts at Q0; hold_i freezes the count (clock stretching).
module i2c_qtick_gen
  import i2c_pkg::*;
#(
  parameter int unsigned QDIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       hold_i,
  output logic       qtick_o,
  output logic [1:0] phase_o,
  output logic [1:0] phase_d_o
);

  localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  // Next count/phase; qtick fires on the last clk of each quarter.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    qtick_o = 1'b0;
    if (clr_i) begin
      cnt_d   = '0;
      phase_d = Q0;
    end else if (hold_i) begin
      cnt_d   = cnt_q;
    end else if (cnt_q == CW'(QDIV - 1)) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
      qtick_o = 1'b1;
    end else begin
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o   = phase_q;
  assign phase_d_o = phase_d;

endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Define I2C_MASTER_STRETCH_EN to let a slave stretch SCL during Q2.
module i2c_master_byte
  import i2c_pkg::*;
#(
  parameter int unsigned QDIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  i2c_master_byte_if.master  bus
);

  i2c_state_e state_q, state_d;
  logic [7:0] sh_q, sh_d, wdata_q, wdata_d, rd_q, rd_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [2:0] bit_q, bit_d;
  logic       rw_q, rw_d, nack_q, nack_d;
  logic       cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic       rsp_valid_q, rsp_valid_d, rsp_nack_q, rsp_nack_d;
  logic       scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic       accept, qtick, hold, slot_end, sample, tx_bit;
  logic [1:0] phase, phase_nx;

  assign accept   = bus.cmd_valid && cmd_ready_q;
  assign slot_end = qtick && (phase == Q3);
  assign sample   = qtick && (phase == Q2);

`ifdef I2C_MASTER_STRETCH_EN
  assign hold = busy_q && (phase == Q2) && !bus.scl_i;
`else
  assign hold = 1'b0;
`endif

  i2c_qtick_gen #(.QDIV(QDIV)) u_qtick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (accept),
    .hold_i    (hold),
    .qtick_o   (qtick),
    .phase_o   (phase),
    .phase_d_o (phase_nx)
  );

  // Transaction sequencing, shifting, sampling and response capture.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    bit_d       = bit_q;
    rw_d        = rw_q;
    nack_d      = nack_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_nack_d  = rsp_nack_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = START;
          sh_d        = {bus.cmd_addr, bus.cmd_rw};
          wdata_d     = bus.cmd_wdata;
          rw_d        = bus.cmd_rw;
          rd_d        = 8'h00;
          nack_d      = 1'b0;
          bit_d       = 3'd0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (slot_end) state_d = ADDR;
        else          state_d = START;
      end
      ADDR, DATA: begin
        if (sample && rw_q && (state_q == DATA)) rd_d = {rd_q[6:0], bus.sda_i};
        else                                     rd_d = rd_q;
        if (slot_end) begin
          sh_d = {sh_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = (state_q == ADDR) ? ACK1 : ACK2;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          sh_d = sh_q;
        end
      end
      ACK1: begin
        if (sample && bus.sda_i) nack_d = 1'b1;
        else                     nack_d = nack_q;
        // nack_q was already updated at the Q2 sample, well before slot end.
        if (slot_end) begin
          sh_d    = wdata_q;
          state_d = nack_q ? STOP : DATA;
        end else begin
          state_d = ACK1;
        end
      end
      ACK2: begin
        if (sample && !rw_q && bus.sda_i) nack_d = 1'b1;
        else                              nack_d = nack_q;
        if (slot_end) state_d = STOP;
        else          state_d = ACK2;
      end
      STOP: begin
        if (slot_end) state_d = DONE;
        else          state_d = STOP;
      end
      DONE: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rd_q;
        rsp_nack_d  = nack_q;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pad drive is computed from next state/phase so the lines move with the phase.
  always_comb begin
    tx_bit = ((state_d == DATA) && rw_d) ? 1'b1 : sh_d[7];
    {scl_oe_d, sda_oe_d} = bus_drive(state_d, phase_nx, tx_bit);
  end

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= 8'h00;
      wdata_q     <= 8'h00;
      rd_q        <= 8'h00;
      bit_q       <= 3'd0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_nack_q  <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      bit_q       <= bit_d;
      rw_q        <= rw_d;
      nack_q      <= nack_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_nack_q  <= rsp_nack_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_nack  = rsp_nack_q;
  assign bus.scl_oe    = scl_oe_q;
  assign bus.sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Directed bench for i2c_master_byte with a clocked behavioural I2C slave on
// pulled-up open-drain lines; latencies counted from the accept edge.
module tb_i2c_master_byte;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  i2c_master_byte_if bus ();

  i2c_master_byte #(.QDIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave side of the wired-AND bus
  logic slv_scl_low = 1'b0;
  logic slv_sda_low = 1'b0;
  logic slv_present = 1'b1;
  logic slv_nack_data = 1'b0;
  logic slv_stretch_en = 1'b0;
  logic [7:0] slv_rdata = 8'h00;

  assign bus.scl_i = ~(bus.scl_oe | slv_scl_low);
  assign bus.sda_i = ~(bus.sda_oe | slv_sda_low);

  int         pc = 0;
  int         pulses = 0;
  int         starts = 0;
  int         stops = 0;
  int         stretch_left = 0;
  logic       stretch_done = 1'b0;
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;
  logic       scl_oe_p = 1'b0;
  logic [7:0] addr_byte = 8'h00;
  logic [7:0] data_byte = 8'h00;
  logic       ack2_level = 1'b0;

  // Behavioural slave, sampling the lines on the falling clk edge.
  always @(negedge clk) begin : slave_model
    logic scl, sda;
    if (slv_stretch_en && (pc == 8) && scl_oe_p && !bus.scl_oe && !stretch_done) begin
      slv_scl_low  = 1'b1;
      stretch_left = 10;
      stretch_done = 1'b1;
    end else if (stretch_left > 0) begin
      stretch_left = stretch_left - 1;
      if (stretch_left == 0) slv_scl_low = 1'b0;
    end
    scl_oe_p = bus.scl_oe;
    scl = ~(bus.scl_oe | slv_scl_low);
    sda = ~(bus.sda_oe | slv_sda_low);
    if (scl_p && scl && sda_p && !sda) begin
      starts++;
      pc = 0;
      stretch_done = 1'b0;
      addr_byte = 8'h00;
      data_byte = 8'h00;
    end else if (scl_p && scl && !sda_p && sda) begin
      stops++;
      pulses = pc - 1;
    end else if (!scl_p && scl) begin
      pc++;
      if (pc <= 8) addr_byte = {addr_byte[6:0], sda};
      else if (pc >= 10 && pc <= 17) data_byte = {data_byte[6:0], sda};
      else if (pc == 18) ack2_level = sda;
    end else if (scl_p && !scl) begin
      if (!slv_present) slv_sda_low = 1'b0;
      else if (pc == 8) slv_sda_low = 1'b1;
      else if (pc >= 9 && pc <= 16 && addr_byte[0]) slv_sda_low = ~slv_rdata[16-pc];
      else if (pc == 17 && !addr_byte[0]) slv_sda_low = ~slv_nack_data;
      else slv_sda_low = 1'b0;
    end
    scl_p = scl;
    sda_p = sda;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int t;
    t = 0;
    while (!bus.rsp_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(t < 3000), 32'd1);
  endtask

  task automatic do_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd, output logic nk);
    int acc, t;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_rw    = rw;
    bus.cmd_wdata = wd;
    t = 0;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    acc = cyc + 1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("ready_drop", 32'(bus.cmd_ready), 32'd0);
    check("busy_set", 32'(bus.busy), 32'd1);
    wait_rsp("rsp_timeout");
    lat = cyc - acc;
    rd  = bus.rsp_rdata;
    nk  = bus.rsp_nack;
    @(negedge clk);
    check("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    check("busy_clear", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat1, acc1, acc2, s0, p0, t, rdy_seen;
    logic [7:0] rd;
    logic nk;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 7'h00;
    bus.cmd_rw    = 1'b0;
    bus.cmd_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_nack", 32'(bus.rsp_nack), 32'd0);
    check("rst_scl_oe", 32'(bus.scl_oe), 32'd0);
    check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write, slave ACKs everything
    s0 = starts; p0 = stops;
    do_cmd(7'h50, 1'b0, 8'hA5, lat, rd, nk);
    check("wr_lat", 32'(lat), 32'd321);
    check("wr_nack", 32'(nk), 32'd0);
    check("wr_rdata", 32'(rd), 32'd0);
    check("wr_addr_byte", 32'(addr_byte), 32'hA0);
    check("wr_data_byte", 32'(data_byte), 32'hA5);
    check("wr_starts", 32'(starts - s0), 32'd1);
    check("wr_stops", 32'(stops - p0), 32'd1);
    check("wr_pulses", 32'(pulses), 32'd18);

    // No slave on the bus
    slv_present = 1'b0;
    s0 = starts; p0 = stops;
    do_cmd(7'h22, 1'b0, 8'h5A, lat, rd, nk);
    check("nak_lat", 32'(lat), 32'd177);
    check("nak_nack", 32'(nk), 32'd1);
    check("nak_pulses", 32'(pulses), 32'd9);
    check("nak_addr_byte", 32'(addr_byte), 32'h44);
    check("nak_stops", 32'(stops - p0), 32'd1);
    check("nak_starts", 32'(starts - s0), 32'd1);
    slv_present = 1'b1;

    // Read, slave returns 0x3C
    slv_rdata = 8'h3C;
    do_cmd(7'h50, 1'b1, 8'hFF, lat, rd, nk);
    check("rd_lat", 32'(lat), 32'd321);
    check("rd_addr_byte", 32'(addr_byte), 32'hA1);
    check("rd_rdata", 32'(rd), 32'h3C);
    check("rd_nack", 32'(nk), 32'd0);
    check("rd_master_nack", 32'(ack2_level), 32'd1);

    // Write with data NACK
    slv_nack_data = 1'b1;
    do_cmd(7'h11, 1'b0, 8'h96, lat, rd, nk);
    check("dnak_lat", 32'(lat), 32'd321);
    check("dnak_nack", 32'(nk), 32'd1);
    check("dnak_pulses", 32'(pulses), 32'd18);
    check("dnak_data_byte", 32'(data_byte), 32'h96);
    slv_nack_data = 1'b0;

    // Reset in the middle of the data byte
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 7'h50;
    bus.cmd_rw    = 1'b0;
    bus.cmd_wdata = 8'h00;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    t = 0;
    while (!(pc == 13 && bus.scl_oe && bus.sda_oe) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("mid_reach", 32'(t < 1000), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_scl_oe", 32'(bus.scl_oe), 32'd0);
    check("mid_sda_oe", 32'(bus.sda_oe), 32'd0);
    check("mid_ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(7'h50, 1'b0, 8'h5A, lat, rd, nk);
    check("post_rst_lat", 32'(lat), 32'd321);
    check("post_rst_data", 32'(data_byte), 32'h5A);
    check("post_rst_nack", 32'(nk), 32'd0);

    // Back-to-back with cmd_valid held high
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 7'h50;
    bus.cmd_rw    = 1'b0;
    bus.cmd_wdata = 8'h11;
    t = 0;
    while (!bus.cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    acc1 = cyc + 1;
    @(negedge clk);
    bus.cmd_addr  = 7'h51;
    bus.cmd_wdata = 8'h22;
    rdy_seen = 0;
    t = 0;
    while (!bus.rsp_valid && t < 3000) begin
      if (bus.cmd_ready) rdy_seen++;
      @(negedge clk);
      t++;
    end
    check("b2b_timeout1", 32'(t < 3000), 32'd1);
    lat1 = cyc - acc1;
    check("b2b_lat1", 32'(lat1), 32'd321);
    check("b2b_ready_low", 32'(rdy_seen), 32'd0);
    check("b2b_d1", 32'(data_byte), 32'h11);
    check("b2b_ready_done", 32'(bus.cmd_ready), 32'd1);
    acc2 = cyc + 1;
    @(negedge clk);
    check("b2b_second_acc", 32'(bus.busy), 32'd1);
    check("b2b_ready_2", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
    wait_rsp("b2b_timeout2");
    check("b2b_lat2", 32'(cyc - acc2), 32'd321);
    check("b2b_addr2", 32'(addr_byte), 32'hA2);
    check("b2b_d2", 32'(data_byte), 32'h22);
    check("b2b_nack2", 32'(bus.rsp_nack), 32'd0);
    @(negedge clk);

`ifdef I2C_MASTER_STRETCH_EN
    // Slave stretches SCL for 10 clk in the address ACK slot
    slv_stretch_en = 1'b1;
    do_cmd(7'h50, 1'b0, 8'hA5, lat, rd, nk);
    check("str_lat", 32'(lat), 32'd331);
    check("str_data", 32'(data_byte), 32'hA5);
    check("str_nack", 32'(nk), 32'd0);
    slv_stretch_en = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte.md
Name: i2c_master_byte

Overview:
- Synthesizable single-byte I2C master; the initiator end of the bus that the team's I2C slave VIP responds to.
- Accepts one command per transaction (7-bit address, R/W, write byte) and performs the full sequence: START, address+R/W, ACK, data byte, ACK/NACK, STOP.
- Returns read data and ACK status.
- Drives open-drain SCL/SDA via output-enables; the SoC pad ring or testbench supplies pull-ups.

Parameters:
- QDIV, 4: clk cycles per quarter SCL period, minimum 2. SCL period = 4*QDIV clk.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  block idle, command accepted when valid&ready
- cmd_addr  input  7  slave address
- cmd_rw  input  1  1=read, 0=write
- cmd_wdata  input  8  byte to write
- rsp_valid  output  1  one-cycle pulse, transaction finished
- rsp_rdata  output  8  byte read (0 for writes)
- rsp_nack  output  1  slave NACKed address or write data
- busy  output  1  transaction in progress
- scl_oe  output  1  1 = pull SCL low
- sda_oe  output  1  1 = pull SDA low
- scl_i  input  1  SCL pad level
- sda_i  input  1  SDA pad level

Behaviour:
- Reset values: cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_nack=0, scl_oe=0, sda_oe=0 (both lines released), state=IDLE.
- Command capture: on valid&ready, latch addr/rw/wdata. Next cycle: cmd_ready=0, busy=1. cmd_* are ignored while busy.
- Bit timing:
  - Every bit slot is 4 quarters (Q0..Q3) of QDIV clk each.
  - Q0/Q1: SCL low. SDA changes only at the start of Q0.
  - Q2/Q3: SCL released. SDA is sampled on the last clk of Q2.
- States: IDLE -> START -> ADDR -> ACK1 -> DATA -> ACK2 -> STOP -> DONE -> IDLE.
- START (one slot): Q0/Q1 SCL and SDA released; Q2 SDA pulled low while SCL is high; Q3 SCL pulled low.
- ADDR: 8 slots, MSB first, sending {addr,rw}.
- ACK1: SDA released; sample. If 1 (NACK), set nack and go to STOP, skipping DATA and ACK2.
- DATA:
  - Write: 8 slots shifting wdata MSB first.
  - Read: SDA released; sampled bits are shifted into rdata MSB first.
- ACK2:
  - Write: SDA released; a sampled 1 sets nack.
  - Read: master releases SDA (NACK, single-byte read).
- STOP (one slot): Q0/Q1 SCL low, SDA low; Q2 SCL released; Q3 SDA released while SCL is high.
- DONE (1 clk): rsp_valid=1, rsp_rdata/rsp_nack updated and held until the next DONE. Then cmd_ready=1, busy=0.
- Latency: rsp_valid occurs exactly 4*QDIV*N + 1 clk after the accept edge.
  - N=20 slots for a full transaction (START + 9 + 9 + STOP).
  - N=11 slots on an address NACK.
- Simultaneous events: cmd_valid asserted during DONE is not accepted until the following cycle (cmd_ready=1).
- Reset mid-transfer: lines are released immediately (asynchronously). No STOP is generated; the slave resynchronises on the next START.
- Arbitration loss and multi-master operation are not supported.
- Without stretching, scl_i is ignored.

Optional Feature:
- Macro: I2C_MASTER_STRETCH_EN.
- Defined: in Q2, the quarter counter holds while scl_i==0 (slave clock stretching). Q2's full QDIV count starts only after scl_i is seen high. Latency becomes minimum rather than exact.
- Undefined: no wait; scl_i unused.

Decomposition:
- Package i2c_pkg holds:
  - state encoding constants (IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE);
  - quarter-phase constants Q0..Q3;
  - the slot count constants 20 and 11.
- One sub-module, i2c_qtick_gen: QDIV counter producing a 1-clk qtick pulse and a 2-bit phase. It has a hold input for stretching and a clear input on accept.

Test Plan:
- Write, QDIV=4, slave ACKs all, cmd addr=0x50 wdata=0xA5 -> slave captures address byte 0xA0 and data 0xA5; rsp_nack=0; rsp_valid at accept+321 clk; START/STOP edges occur with SCL high.
- No slave (pull-ups only), addr=0x22 -> exactly 9 SCL pulses, then STOP; rsp_nack=1; rsp_valid at accept+177 clk.
- Read, slave returns 0x3C, addr=0x50 -> address byte 0xA1 on the bus; rsp_rdata=0x3C; SDA high on the 18th SCL pulse (master NACK).
- Write with data NACK (slave ACKs address, NACKs data) -> rsp_nack=1; the full 20-slot sequence completes.
- Assert rst_n low during DATA bit 3 -> scl_oe=sda_oe=0 and cmd_ready=1 with no clk edge; a subsequent command completes normally.
- Back-to-back: cmd_valid held high with two commands -> second accepted the cycle after DONE; cmd_ready=0 throughout the first. With I2C_MASTER_STRETCH_EN, the slave holds SCL low for 10 clk at ACK1 -> rsp_valid delayed by exactly 10 clk.
